divider_pipeline: RTL and testbench



---
 rtl/divider_pipeline.sv | 91 +++++++++
 tb/tb_divider_pipeline.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/divider_pipeline.sv
// Fully pipelined unsigned restoring divider: one quotient bit per stage, MSB first,
// one operation per clock, WIDTH-cycle latency, registered outputs.
module divider_pipeline #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Per-stage state. acc holds the dividend bits still to be consumed in its upper
  // part and the quotient bits produced so far in its lower part; each stage shifts
  // it left by one, so after the last stage it is exactly the quotient.
  logic [WIDTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_dbz;
  logic [WIDTH-1:0] stg_div [WIDTH];
  logic [WIDTH-1:0] stg_acc [WIDTH];
  logic [WIDTH-1:0] stg_rem [WIDTH];

  logic [WIDTH-1:0] src_valid;
  logic [WIDTH-1:0] src_dbz;
  logic [WIDTH-1:0] src_div [WIDTH];
  logic [WIDTH-1:0] src_acc [WIDTH];
  logic [WIDTH-1:0] src_rem [WIDTH];

  logic [WIDTH:0]   trial   [WIDTH];
  logic [WIDTH-1:0] take;
  logic [WIDTH-1:0] nxt_acc [WIDTH];
  logic [WIDTH-1:0] nxt_rem [WIDTH];

  always_comb begin
    src_valid  = {stg_valid[WIDTH-2:0], in_valid};
    src_dbz    = {stg_dbz[WIDTH-2:0], (divisor == '0)};
    src_div[0] = divisor;
    src_acc[0] = dividend;
    src_rem[0] = '0;
    for (int k = 1; k < WIDTH; k++) begin
      src_div[k] = stg_div[k-1];
      src_acc[k] = stg_acc[k-1];
      src_rem[k] = stg_rem[k-1];
    end
  end

  // Compare and subtract are WIDTH+1 bits; when the subtraction is taken the
  // result is below the divisor, so its low WIDTH bits are the whole answer.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      trial[k]   = {src_rem[k], src_acc[k][WIDTH-1]};
      take[k]    = (trial[k] >= {1'b0, src_div[k]});
      nxt_rem[k] = take[k] ? (trial[k][WIDTH-1:0] - src_div[k]) : trial[k][WIDTH-1:0];
      nxt_acc[k] = {src_acc[k][WIDTH-2:0], take[k]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stg_valid   <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      stg_valid <= src_valid;
      out_valid <= stg_valid[WIDTH-1];
      if (stg_valid[WIDTH-1]) begin
        quotient    <= stg_acc[WIDTH-1];
        remainder   <= stg_rem[WIDTH-1];
        div_by_zero <= stg_dbz[WIDTH-1];
      end
    end
  end

  // Data registers need no reset: they are only observed behind a valid bit.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < WIDTH; k++) begin
      if (src_valid[k]) begin
        stg_div[k] <= src_div[k];
        stg_acc[k] <= nxt_acc[k];
        stg_rem[k] <= nxt_rem[k];
        stg_dbz[k] <= src_dbz[k];
      end
    end
  end

endmodule

// File: tb/tb_divider_pipeline.sv
// Directed bench for divider_pipeline: latency, corners, divide by zero, streaming,
// reset flush and a full-rate sweep of every 8-bit operand pair.
module tb_divider_pipeline;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  divider_pipeline #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           cyc;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  res_t obs[$];
  res_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
    if (out_valid === 1'b1) obs.push_back('{cyc, quotient, remainder, div_by_zero});
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
  endtask

  function automatic res_t model(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t x;
    x.cyc = c;
    x.dbz = (b == 0);
    x.q   = (b == 0) ? 8'hFF : a / b;
    x.r   = (b == 0) ? a : a % b;
    return x;
  endfunction

  // One isolated operation: silent for 7 edges, one pulse on the 8th, values checked.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
    int early;
    early = 0;
    drive(a, b);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (out_valid !== 1'b0) early++;
    end
    chk({tag, "_early"}, early, 0);
    tick();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    int base;
    int bad;
    int nvalid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t o;

    tick();
    tick();
    RST = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);

    run_one("basic", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
    nvalid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid !== 1'b0) nvalid++;
    end
    chk("basic_pulse_once", nvalid, 0);
    chk("basic_hold_q", quotient, 28);
    chk("basic_hold_r", remainder, 4);

    run_one("c255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run_one("c255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    run_one("c5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run_one("c0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    run_one("dbz100", 8'd100, 8'd0, 8'd255, 8'd100, 1'b1);
    run_one("after_dbz", 8'd10, 8'd3, 8'd3, 8'd1, 1'b0);

    // Streaming: 16 on, 3 off, 4 on; pulses must repeat the pattern 8 edges later.
    obs.delete();
    exp_q.delete();
    for (int i = 0; i < 23; i++) begin
      if (i >= 16 && i < 19) begin
        in_valid = 1'b0;
        tick();
      end else begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        if (i == 5) b = '0;
        drive(a, b);
        exp_q.push_back(model(cyc + 8, a, b));
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("stream_count", obs.size(), 20);
    for (int i = 0; i < 20 && i < obs.size(); i++) begin
      chk($sformatf("stream%0d_cyc", i), obs[i].cyc, exp_q[i].cyc);
      chk($sformatf("stream%0d_q", i), obs[i].q, exp_q[i].q);
      chk($sformatf("stream%0d_r", i), obs[i].r, exp_q[i].r);
      chk($sformatf("stream%0d_dbz", i), obs[i].dbz, exp_q[i].dbz);
    end

    // Reset flush: four accepted ops in flight, a fifth presented together with RST.
    obs.delete();
    drive(8'd31, 8'd4);
    drive(8'd90, 8'd9);
    drive(8'd250, 8'd13);
    drive(8'd64, 8'd8);
    RST = 1'b1;
    drive(8'd123, 8'd3);
    RST = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_q", quotient, 0);
    chk("flush_r", remainder, 0);
    chk("flush_dbz", div_by_zero, 0);
    tick();
    drive(8'd77, 8'd5);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("flush_no_pulse", obs.size(), 0);
    tick();
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_q", quotient, 15);
    chk("post_rst_r", remainder, 2);
    chk("post_rst_dbz", div_by_zero, 0);

    // Exhaustive sweep at full rate.
    for (int i = 0; i < 4; i++) tick();
    obs.delete();
    base = cyc + 1;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) drive(W'(x), W'(y));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("sweep_count", obs.size(), 65536);
    bad = 0;
    for (int i = 0; i < obs.size() && i < 65536; i++) begin
      o = obs[i];
      a = W'(i >> 8);
      b = W'(i & 255);
      if (o.cyc != base + 8 + i) bad++;
      else if (b == 0) begin
        if (!(o.dbz === 1'b1 && o.q === 8'hFF && o.r === a)) bad++;
      end else begin
        if (!(o.dbz === 1'b0 && (int'(o.q) * int'(b) + int'(o.r)) == int'(a) && o.r < b)) bad++;
      end
    end
    chk("sweep_bad", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
